ps2_scancode_decoder: RTL and testbench
=======================================

# ps2_scancode_decoder

Consumes the byte stream from the PS/2 device-to-host receiver (8-bit byte plus one-cycle ready strobe). Folds Set-2 scancode prefixes (E0 extended, F0 break, E1 pause sequence) into single key events. Buffers events in a small show-ahead FIFO for a consumer with a valid/ack handshake, and tracks live modifier-key state. Sits directly downstream of the PS/2 receiver in the keyboard path.

## Interface
- FIFO_DEPTH, 4, event FIFO depth; power of 2, ≥2
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- byte_in  in  8  received byte; valid only when byte_ready=1
- byte_ready  in  1  one-cycle strobe from receiver; may be high on consecutive cycles
- ev_code  out  8  head-of-FIFO scancode (final byte of sequence)
- ev_ext  out  1  head event was E0-prefixed
- ev_break  out  1  head event is a release (F0-prefixed)
- ev_valid  out  1  FIFO non-empty
- ev_ack  in  1  pop head; ignored when ev_valid=0
- mods  out  4  {alt, ctrl, rshift, lshift}, 1 = held
- overflow  out  1  sticky: event dropped on full FIFO
- ovf_clr  in  1  synchronous clear of overflow

## Operation
- Reset: FSM=IDLE, FIFO empty, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, mods=0, overflow=0, pause counter=0. Reset mid-sequence discards the partial prefix.
- Bytes are processed only on cycles with byte_ready=1.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
- IDLE:
  - E0→EXT
  - F0→BRK
  - E1→PAUSE, counter=7
  - other→emit {ext=0,brk=0}
- EXT:
  - F0→EXT_BRK
  - E0→EXT (restart)
  - other→emit {1,0}, IDLE
- BRK:
  - F0→BRK (duplicate ignored)
  - E0→EXT (restart, break flag lost)
  - other→emit {0,1}, IDLE
- EXT_BRK:
  - F0→stay
  - E0→EXT
  - other→emit {1,1}, IDLE
- PAUSE: every byte decrements the counter, content ignored. When the counter reaches 0 (7th byte after E1), emit {code=E1, ext=0, brk=0} and go to IDLE.
- Filtered bytes 00, AA, EE, FA, FE, FF in any state except PAUSE: dropped, no event, FSM→IDLE.
- Modifiers update on every emitted event, independent of FIFO space:
  - code 12 with ext=0 → lshift = !brk
  - code 59 with ext=0 → rshift = !brk
  - code 14 (any ext) → ctrl = !brk
  - code 11 (any ext) → alt = !brk
  - code E1 → no modifier change
- FIFO is show-ahead; outputs always reflect the head entry. Entry = {ext, brk, code[7:0]}, 10 bits. Binary read/write pointers carry one extra wrap bit.
- Push when an event is emitted and (not full, or full with ev_ack=1 the same cycle). Otherwise the event is dropped and overflow←1.
- Simultaneous push and pop on empty: ack ignored, push proceeds.
- overflow: set has priority over ovf_clr in the same cycle.

## Timing
- byte_ready at cycle N with a terminal byte → FIFO write and mods update at the rising edge ending N. ev_valid=1 and head outputs valid in N+1. Latency is 1 cycle.
- ev_ack at cycle M with ev_valid=1 → next entry (or ev_valid=0) in M+1.
- A prefix byte costs no output cycle. Back-to-back strobes are processed one byte per cycle with no stalls.
- No backpressure to the receiver. The receiver cannot be stalled; loss is signalled only via overflow.

## Test plan
- Reset, then byte 1C → ev_valid=1 one cycle after strobe, ev_code=1C, ev_ext=0, ev_break=0; ack → ev_valid=0 next cycle.
- F0, 1C → single event 1C, ev_break=1, ev_ext=0. E0, F0, 75 → single event 75, ext=1, brk=1. No events emitted for prefix bytes.
- 12, 14, E0 11, F0 12 → mods goes 0001, 0101, 1101, 1100. Event FIFO holds 4 events in order.
- E1 14 77 E1 F0 14 F0 77 on consecutive cycles → exactly one event {E1,0,0}, mods unchanged. Follow-up 1C decodes normally.
- FIFO_DEPTH=4, five make codes 15,16,1E,26,25 with no ack → ev_valid=1, overflow=1, popped order 15,16,1E,26. Refill to full, then a push with ev_ack in the same cycle → no overflow, accepted. Set and ovf_clr in the same cycle → overflow stays 1.
- Byte E0, then rst low for 1 cycle mid-idle → all outputs 0. Then 75 → event ext=0. Filtered FA between E0 and 75 → event 75 with ext=0.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder.
// Folds E0/F0/E1 prefixes into single key events, keeps live modifier state
// and queues events in a small show-ahead FIFO with a valid/ack handshake.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic [7:0] byte_in,
    input  logic       byte_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_valid,
    input  logic       ev_ack,
    output logic [3:0] mods,       // {alt, ctrl, rshift, lshift}
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;

    logic        emit;
    logic        emit_ext;
    logic        emit_brk;
    logic [7:0]  emit_code;
    logic        is_filtered;

    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic        fifo_empty, fifo_full;
    logic        push, pop;
    logic [9:0]  head;

    logic [3:0]  mods_reg;
    logic        overflow_reg;

    // Control/ack bytes from the keyboard that never form part of a key event.
    always_comb begin
        is_filtered = 1'b0;
        case (byte_in)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_filtered = 1'b1;
            default:                                  is_filtered = 1'b0;
        endcase
    end

    // Prefix-folding FSM: next state, pause counter and event emission.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_brk   = 1'b0;
        emit_code  = byte_in;
        if (byte_ready) begin
            if (state_reg == ST_PAUSE) begin
                // Pause sequence content is ignored; only the byte count matters.
                cnt_next = cnt_reg - 3'd1;
                if (cnt_reg <= 3'd1) begin
                    emit       = 1'b1;
                    emit_code  = 8'hE1;
                    cnt_next   = 3'd0;
                    state_next = ST_IDLE;
                end
            end else if (is_filtered) begin
                state_next = ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (byte_in == 8'hE0) begin
                            state_next = ST_EXT;
                        end else if (byte_in == 8'hF0) begin
                            state_next = ST_BRK;
                        end else if (byte_in == 8'hE1) begin
                            state_next = ST_PAUSE;
                            cnt_next   = 3'd7;
                        end else begin
                            emit = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (byte_in == 8'hF0) begin
                            state_next = ST_EXT_BRK;
                        end else if (byte_in == 8'hE0) begin
                            state_next = ST_EXT;
                        end else begin
                            emit       = 1'b1;
                            emit_ext   = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        if (byte_in == 8'hF0) begin
                            state_next = ST_BRK;
                        end else if (byte_in == 8'hE0) begin
                            state_next = ST_EXT;
                        end else begin
                            emit       = 1'b1;
                            emit_brk   = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                    ST_EXT_BRK: begin
                        if (byte_in == 8'hF0) begin
                            state_next = ST_EXT_BRK;
                        end else if (byte_in == 8'hE0) begin
                            state_next = ST_EXT;
                        end else begin
                            emit       = 1'b1;
                            emit_ext   = 1'b1;
                            emit_brk   = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    // FSM state and pause counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Modifier tracking follows every emitted event, even ones the FIFO drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mods_reg <= 4'b0000;
        end else if (emit) begin
            if (emit_code == 8'h12 && !emit_ext) mods_reg[0] <= !emit_brk;
            if (emit_code == 8'h59 && !emit_ext) mods_reg[1] <= !emit_brk;
            if (emit_code == 8'h14)              mods_reg[2] <= !emit_brk;
            if (emit_code == 8'h11)              mods_reg[3] <= !emit_brk;
        end
    end

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // A pop on a full FIFO frees the slot being written in the same cycle.
    assign push       = emit && (!fifo_full || ev_ack);
    assign pop        = ev_ack && !fifo_empty;

    // Event storage; the head is read combinationally for show-ahead output.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= {emit_ext, emit_brk, emit_code};
        end
    end

    // FIFO pointers with an extra wrap bit to separate full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Sticky overflow; a new drop wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_reg <= 1'b0;
        end else if (emit && !push) begin
            overflow_reg <= 1'b1;
        end else if (ovf_clr) begin
            overflow_reg <= 1'b0;
        end
    end

    // Head outputs read as zero while the FIFO is empty.
    assign head     = fifo_empty ? 10'd0 : mem[rd_ptr_reg[AW-1:0]];
    assign ev_valid = !fifo_empty;
    assign ev_ext   = head[9];
    assign ev_break = head[8];
    assign ev_code  = head[7:0];
    assign mods     = mods_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder.
`timescale 1ns/1ps
module tb_ps2_scancode_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_ready = 1'b0;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_valid;
    logic       ev_ack = 1'b0;
    logic [3:0] mods;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_ready (byte_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_break   (ev_break),
        .ev_valid   (ev_valid),
        .ev_ack     (ev_ack),
        .mods       (mods),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One strobe cycle; starts and ends just after a falling edge.
    task automatic strobe(input logic [7:0] b, input logic ack, input logic clr);
        byte_in    = b;
        byte_ready = 1'b1;
        ev_ack     = ack;
        ovf_clr    = clr;
        @(negedge clk);
        byte_ready = 1'b0;
        ev_ack     = 1'b0;
        ovf_clr    = 1'b0;
        $display("tx byte=%02h ack=%0b clr=%0b -> valid=%0b code=%02h ext=%0b brk=%0b mods=%04b ovf=%0b",
                 b, ack, clr, ev_valid, ev_code, ev_ext, ev_break, mods, overflow);
    endtask

    task automatic pop();
        ev_ack = 1'b1;
        @(negedge clk);
        ev_ack = 1'b0;
        $display("tx pop -> valid=%0b code=%02h ext=%0b brk=%0b", ev_valid, ev_code, ev_ext, ev_break);
    endtask

    task automatic head(input string tag, input logic [7:0] code, input logic ext, input logic brk);
        check({tag, "_valid"}, 32'(ev_valid), 32'd1);
        check({tag, "_code"},  32'(ev_code),  32'(code));
        check({tag, "_ext"},   32'(ev_ext),   32'(ext));
        check({tag, "_brk"},   32'(ev_break), 32'(brk));
    endtask

    task automatic ovf_clear();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        $display("tx ovf_clr -> ovf=%0b", overflow);
    endtask

    logic [7:0] pause_seq [8];
    logic [7:0] fill_seq [4];

    initial begin
        pause_seq[0] = 8'hE1; pause_seq[1] = 8'h14; pause_seq[2] = 8'h77; pause_seq[3] = 8'hE1;
        pause_seq[4] = 8'hF0; pause_seq[5] = 8'h14; pause_seq[6] = 8'hF0; pause_seq[7] = 8'h77;
        fill_seq[0] = 8'h15; fill_seq[1] = 8'h16; fill_seq[2] = 8'h1E; fill_seq[3] = 8'h26;

        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_code",  32'(ev_code),  32'd0);
        check("rst_mods",  32'(mods),     32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Plain make code, one-cycle latency, ack empties
        strobe(8'h1C, 1'b0, 1'b0);
        head("make", 8'h1C, 1'b0, 1'b0);
        pop();
        check("make_popped", 32'(ev_valid), 32'd0);

        // Break code
        strobe(8'hF0, 1'b0, 1'b0);
        check("brk_prefix_noev", 32'(ev_valid), 32'd0);
        strobe(8'h1C, 1'b0, 1'b0);
        head("brk", 8'h1C, 1'b0, 1'b1);
        pop();

        // Extended break
        strobe(8'hE0, 1'b0, 1'b0);
        strobe(8'hF0, 1'b0, 1'b0);
        check("extbrk_prefix_noev", 32'(ev_valid), 32'd0);
        strobe(8'h75, 1'b0, 1'b0);
        head("extbrk", 8'h75, 1'b1, 1'b1);
        pop();
        check("extbrk_single", 32'(ev_valid), 32'd0);

        // Modifiers
        strobe(8'h12, 1'b0, 1'b0);
        check("mods_lshift", 32'(mods), 32'b0001);
        strobe(8'h14, 1'b0, 1'b0);
        check("mods_ctrl", 32'(mods), 32'b0101);
        strobe(8'hE0, 1'b0, 1'b0);
        strobe(8'h11, 1'b0, 1'b0);
        check("mods_alt", 32'(mods), 32'b1101);
        strobe(8'hF0, 1'b0, 1'b0);
        strobe(8'h12, 1'b0, 1'b0);
        check("mods_lshift_rel", 32'(mods), 32'b1100);
        head("mq0", 8'h12, 1'b0, 1'b0); pop();
        head("mq1", 8'h14, 1'b0, 1'b0); pop();
        head("mq2", 8'h11, 1'b1, 1'b0); pop();
        head("mq3", 8'h12, 1'b0, 1'b1); pop();
        check("mq_empty", 32'(ev_valid), 32'd0);

        // Pause sequence, back-to-back strobes
        for (int i = 0; i < 8; i++) begin
            strobe(pause_seq[i], 1'b0, 1'b0);
            if (i < 7) check("pause_noev", 32'(ev_valid), 32'd0);
        end
        head("pause", 8'hE1, 1'b0, 1'b0);
        check("pause_mods", 32'(mods), 32'b1100);
        pop();
        check("pause_single", 32'(ev_valid), 32'd0);
        strobe(8'h1C, 1'b0, 1'b0);
        head("after_pause", 8'h1C, 1'b0, 1'b0);
        pop();

        // Overflow on five events into a depth-4 FIFO
        for (int i = 0; i < 4; i++) strobe(fill_seq[i], 1'b0, 1'b0);
        check("fill_no_ovf", 32'(overflow), 32'd0);
        strobe(8'h25, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_valid", 32'(ev_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            head("ovf_order", fill_seq[i], 1'b0, 1'b0);
            pop();
        end
        check("ovf_drained", 32'(ev_valid), 32'd0);
        ovf_clear();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO with same-cycle ack accepts the push
        for (int i = 0; i < 4; i++) strobe(fill_seq[i], 1'b0, 1'b0);
        strobe(8'h29, 1'b1, 1'b0);
        check("full_ack_no_ovf", 32'(overflow), 32'd0);
        head("full_ack_h0", 8'h16, 1'b0, 1'b0); pop();
        head("full_ack_h1", 8'h1E, 1'b0, 1'b0); pop();
        head("full_ack_h2", 8'h26, 1'b0, 1'b0); pop();
        head("full_ack_h3", 8'h29, 1'b0, 1'b0); pop();
        check("full_ack_empty", 32'(ev_valid), 32'd0);

        // Set and clear in the same cycle: set wins
        for (int i = 0; i < 4; i++) strobe(fill_seq[i], 1'b0, 1'b0);
        strobe(8'h25, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(overflow), 32'd1);
        ovf_clear();
        check("ovf_clr_alone", 32'(overflow), 32'd0);

        // Reset mid-prefix discards the prefix and flushes everything
        strobe(8'hE0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("mrst_valid", 32'(ev_valid), 32'd0);
        check("mrst_code",  32'(ev_code),  32'd0);
        check("mrst_ext",   32'(ev_ext),   32'd0);
        check("mrst_brk",   32'(ev_break), 32'd0);
        check("mrst_mods",  32'(mods),     32'd0);
        check("mrst_ovf",   32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        strobe(8'h75, 1'b0, 1'b0);
        head("post_rst", 8'h75, 1'b0, 1'b0);
        pop();

        // Filtered byte cancels a pending prefix
        strobe(8'hE0, 1'b0, 1'b0);
        strobe(8'hFA, 1'b0, 1'b0);
        check("filt_noev", 32'(ev_valid), 32'd0);
        strobe(8'h75, 1'b0, 1'b0);
        head("filt", 8'h75, 1'b0, 1'b0);
        pop();
        check("filt_single", 32'(ev_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
